multimode_counter: RTL and testbench



---
 rtl/multimode_counter_pkg.sv | 24 ++
 rtl/multimode_counter_johnson_step.sv | 19 +
 rtl/multimode_counter.sv | 129 ++++++++++++
 tb/tb_multimode_counter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/multimode_counter_pkg.sv
// Shared mode encodings and the Johnson code-validity check for multimode_counter.
package multimode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_JOHN = 2'b10,
    MODE_PING = 2'b11
  } mode_e;

  localparam int MAX_W = 32;

  // A Johnson code has at most one transition between adjacent bits,
  // which covers both 1..10..0 and 0..01..1 forms (all-zero and all-one included).
  function automatic logic is_johnson(input logic [MAX_W-1:0] code, input int width);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if ((i < width - 1) && (code[i] != code[i+1])) n++;
    end
    return (n <= 1);
  endfunction

endpackage

// File: rtl/multimode_counter_johnson_step.sv
// Combinational Johnson next-state: shift right with inverted LSB fed back into the MSB.
module johnson_step
  import multimode_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next,
  output logic             valid,
  output logic             wraps
);

  always_comb begin
    valid = is_johnson(MAX_W'(count), WIDTH);
    next  = valid ? {~count[0], count[WIDTH-1:1]} : '0;
    wraps = valid && (count == WIDTH'(1));
  end

endmodule

// File: rtl/multimode_counter.sv
// Run-time selectable up/down/Johnson/ping-pong counter with load, enable and wrap/illegal pulses.
module multimode_counter
  import multimode_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             wrap,
  output logic             illegal
);

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] john_next;
  logic             john_valid;
  logic             john_wraps;
  logic [WIDTH:0]   up_wide;
  logic [WIDTH-1:0] dec;

  johnson_step #(.WIDTH(WIDTH)) u_john (
    .count (count_q),
    .next  (john_next),
    .valid (john_valid),
    .wraps (john_wraps)
  );

  // Widened increment so the ping-pong compare cannot alias when count+1 overflows.
  assign up_wide = {1'b0, count_q} + (WIDTH+1)'(1);
  assign dec     = count_q - WIDTH'(1);

  always_comb begin
    mode_d    = mode_q;
    count_d   = count_q;
    dir_d     = dir_q;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    if (load) begin
      count_d = load_value;
      dir_d   = 1'b0;
      mode_d  = mode_e'(mode);
    end else if (mode != mode_q) begin
      count_d = '0;
      dir_d   = 1'b0;
      mode_d  = mode_e'(mode);
    end else if (enable) begin
      if (mode_q != MODE_JOHN && limit == '0) begin
        count_d = '0;
        dir_d   = 1'b0;
        wrap_d  = 1'b1;
      end else begin
        case (mode_q)
          MODE_UP: begin
            if (count_q >= limit) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = up_wide[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            if (count_q == '0 || count_q > limit) begin
              count_d = limit;
              wrap_d  = (count_q == '0);
            end else begin
              count_d = dec;
            end
          end
          MODE_JOHN: begin
            count_d   = john_next;
            wrap_d    = john_wraps;
            illegal_d = ~john_valid;
          end
          default: begin
            if (!dir_q) begin
              if (up_wide >= {1'b0, limit}) begin
                count_d = limit;
                dir_d   = 1'b1;
              end else begin
                count_d = up_wide[WIDTH-1:0];
              end
            end else if (count_q > limit) begin
              count_d = limit;
            end else begin
              count_d = dec;
              if (dec == '0) begin
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q    <= MODE_UP;
      count_q   <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      illegal_q <= illegal_d;
    end
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign wrap    = wrap_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: directed sequences with literal expectations plus random stimulus vs a behavioural model.
module tb_multimode_counter;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] limit = '0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         dir, wrap, illegal;

  int checks = 0;
  int failures = 0;

  int  m_count = 0, m_dir = 0, m_wrap = 0, m_ill = 0, m_mode = 0;
  bit  m_valid = 1'b0;

  int exp_down[7]  = '{5, 4, 3, 2, 1, 0, 5};
  int exp_john[8]  = '{8, 12, 14, 15, 7, 3, 1, 0};
  int exp_ping[7]  = '{1, 2, 3, 2, 1, 0, 1};
  int exp_pdir[7]  = '{0, 0, 1, 1, 1, 0, 0};
  int exp_pwrap[7] = '{0, 0, 0, 0, 0, 1, 0};

  multimode_counter #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .limit      (limit),
    .load       (load),
    .load_value (load_value),
    .count      (count),
    .dir        (dir),
    .wrap       (wrap),
    .illegal    (illegal)
  );

  always #5 clock = ~clock;

  function automatic bit john_ok(input int c);
    for (int k = 0; k <= W; k++) begin
      if (c == ((1 << k) - 1) || c == (MASK ^ ((1 << k) - 1))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: the counting rules applied to plain integers on each rising edge.
  always @(posedge clock) begin
    int lim;
    lim = int'(limit);
    m_wrap = 0;
    m_ill  = 0;
    if (reset) begin
      m_count = 0; m_dir = 0; m_mode = 0; m_valid = 1'b1;
    end else if (load) begin
      m_count = int'(load_value); m_dir = 0; m_mode = int'(mode);
    end else if (int'(mode) != m_mode) begin
      m_count = 0; m_dir = 0; m_mode = int'(mode);
    end else if (enable) begin
      if (m_mode != 2 && lim == 0) begin
        m_count = 0; m_dir = 0; m_wrap = 1;
      end else if (m_mode == 0) begin
        if (m_count >= lim) begin m_count = 0; m_wrap = 1; end
        else m_count = m_count + 1;
      end else if (m_mode == 1) begin
        if (m_count == 0) begin m_count = lim; m_wrap = 1; end
        else if (m_count > lim) m_count = lim;
        else m_count = m_count - 1;
      end else if (m_mode == 2) begin
        if (john_ok(m_count)) begin
          m_count = (m_count >> 1) | (((~m_count) & 1) << (W - 1));
          m_wrap  = (m_count == 0);
        end else begin
          m_count = 0; m_ill = 1;
        end
      end else begin
        if (m_dir == 0) begin
          if (m_count + 1 >= lim) begin m_count = lim; m_dir = 1; end
          else m_count = m_count + 1;
        end else if (m_count > lim) begin
          m_count = lim;
        end else begin
          m_count = (m_count - 1) & MASK;
          if (m_count == 0) begin m_dir = 0; m_wrap = 1; end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      checks++;
      if (int'(count) != m_count || int'(dir) != m_dir || int'(wrap) != m_wrap || int'(illegal) != m_ill) begin
        failures++;
        $display("FAIL model t=%0t count=%0d dir=%0d wrap=%0d illegal=%0d required count=%0d dir=%0d wrap=%0d illegal=%0d",
                 $time, count, dir, wrap, illegal, m_count, m_dir, m_wrap, m_ill);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  initial begin
    reset = 1'b1;
    step(2);
    chk("reset_count", int'(count), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_illegal", int'(illegal), 0);
    reset = 1'b0;

    // UP, limit 9, then shrink limit while above it
    mode = 2'b00; limit = 4'd9; enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("up_count", int'(count), k % 10);
      chk("up_wrap", int'(wrap), (k == 10) ? 1 : 0);
    end
    step(8);
    chk("up_pre_limit", int'(count), 8);
    limit = 4'd5;
    step(1);
    chk("up_limit_count", int'(count), 0);
    chk("up_limit_wrap", int'(wrap), 1);

    // DOWN from reset
    reset = 1'b1; step(1); reset = 1'b0;
    mode = 2'b01; limit = 4'd5;
    step(1);
    chk("down_modechg", int'(count), 0);
    chk("down_modechg_wrap", int'(wrap), 0);
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk("down_count", int'(count), exp_down[k]);
      chk("down_wrap", int'(wrap), (k == 0 || k == 6) ? 1 : 0);
    end

    // JOHN sequence and illegal code
    mode = 2'b10;
    step(1);
    chk("john_modechg", int'(count), 0);
    for (int k = 0; k < 8; k++) begin
      step(1);
      chk("john_count", int'(count), exp_john[k]);
      chk("john_wrap", int'(wrap), (k == 7) ? 1 : 0);
    end
    load = 1'b1; load_value = 4'b0101;
    step(1);
    chk("john_load", int'(count), 5);
    load = 1'b0;
    step(1);
    chk("john_illegal_count", int'(count), 0);
    chk("john_illegal", int'(illegal), 1);
    chk("john_illegal_wrap", int'(wrap), 0);

    // PING, limit 3, then limit 0
    mode = 2'b11; limit = 4'd3;
    step(1);
    chk("ping_modechg", int'(count), 0);
    for (int k = 0; k < 7; k++) begin
      step(1);
      chk("ping_count", int'(count), exp_ping[k]);
      chk("ping_dir", int'(dir), exp_pdir[k]);
      chk("ping_wrap", int'(wrap), exp_pwrap[k]);
    end
    limit = 4'd0;
    for (int k = 0; k < 2; k++) begin
      step(1);
      chk("ping_lim0_count", int'(count), 0);
      chk("ping_lim0_wrap", int'(wrap), 1);
      chk("ping_lim0_dir", int'(dir), 0);
    end

    // Priority: load beats mode change and enable; reset beats load
    load = 1'b1; load_value = 4'd7; mode = 2'b00; enable = 1'b1;
    step(1);
    chk("prio_load_count", int'(count), 7);
    chk("prio_load_wrap", int'(wrap), 0);
    reset = 1'b1; load_value = 4'd9;
    step(1);
    chk("prio_reset_count", int'(count), 0);
    chk("prio_reset_wrap", int'(wrap), 0);
    reset = 1'b0; load = 1'b0;

    // Freeze with enable low
    limit = 4'd9;
    step(3);
    chk("freeze_pre", int'(count), 3);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("freeze_count", int'(count), 3);
      chk("freeze_wrap", int'(wrap), 0);
    end
    enable = 1'b1;
    step(1);
    chk("freeze_resume", int'(count), 4);

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load       = ($urandom_range(0, 19) == 0);
      load_value = W'($urandom);
      enable     = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) limit = W'($urandom_range(0, 15));
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
